// File: rtl/crypt_stream_pipe.sv
// crypt_stream_pipe: streaming keyed byte-transform pipeline.
// NUM_STAGES registered rounds, one 32-bit word per cycle, valid/ready on both
// sides. Each word carries its own key and mode; outputs are framed into
// blocks of NUM_WORDS with out_last and a registered block_done pulse.
module crypt_stream_pipe #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_WORDS  = 4,
    parameter int KEY_W      = 2 * NUM_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [KEY_W-1:0] in_key,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             block_done,
    output logic [3:0]       occupancy
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // Forward round selected by a 2-bit key pair.
    function automatic logic [31:0] round_fwd(input logic [1:0] p, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        case (p)
            2'b00: r = {w[23:0], w[31:24]};
            2'b01: r = w ^ 32'hA5A5A5A5;
            2'b10: for (int b = 0; b < 4; b++) r[8*b +: 8] = {w[8*b +: 7], w[8*b+7]};
            2'b11: for (int b = 0; b < 4; b++) r[8*b +: 8] = {w[8*b +: 4], w[8*b+4 +: 4]};
        endcase
        return r;
    endfunction

    // Inverse round; XOR and nibble swap are their own inverses.
    function automatic logic [31:0] round_inv(input logic [1:0] p, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        case (p)
            2'b00: r = {w[7:0], w[31:8]};
            2'b01: r = w ^ 32'hA5A5A5A5;
            2'b10: for (int b = 0; b < 4; b++) r[8*b +: 8] = {w[8*b], w[8*b+1 +: 7]};
            2'b11: for (int b = 0; b < 4; b++) r[8*b +: 8] = {w[8*b +: 4], w[8*b+4 +: 4]};
        endcase
        return r;
    endfunction

    logic advance;
    logic in_hs;
    logic out_hs;

    // Global stall: the whole pipe moves together, bubbles included.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic [31:0]      src_data;
        logic [KEY_W-1:0] src_key;
        logic             src_mode;
        logic             src_valid;
        logic [1:0]       pair;
        logic [31:0]      data_q;
        logic             valid_q;

        if (i == 0) begin : g_first
            assign src_data  = in_data;
            assign src_key   = in_key;
            assign src_mode  = in_mode;
            assign src_valid = in_valid;
        end else begin : g_rest
            assign src_data  = g_stage[i-1].data_q;
            assign src_key   = g_stage[i-1].g_meta.key_q;
            assign src_mode  = g_stage[i-1].g_meta.mode_q;
            assign src_valid = g_stage[i-1].valid_q;
        end

        // Encrypt walks key pairs MS-first; decrypt walks them LS-first.
        assign pair = src_mode ? src_key[2*i +: 2] : src_key[2*(NUM_STAGES-1-i) +: 2];

        // Stage register: transformed word and its valid bit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= src_mode ? round_inv(pair, src_data) : round_fwd(pair, src_data);
                valid_q <= src_valid;
            end
        end

        // Key and mode travel with the word; the final stage has no consumer for them.
        if (i < NUM_STAGES - 1) begin : g_meta
            logic [KEY_W-1:0] key_q;
            logic             mode_q;

            // Per-word key/mode carried alongside the data.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    key_q  <= '0;
                    mode_q <= 1'b0;
                end else if (advance) begin
                    key_q  <= src_key;
                    mode_q <= src_mode;
                end
            end
        end
    end

    assign out_valid = g_stage[NUM_STAGES-1].valid_q;
    assign out_data  = g_stage[NUM_STAGES-1].data_q;

    logic [IDX_W-1:0] out_idx_q;
    logic             block_done_q;
    logic [3:0]       occ_q;

    assign out_last   = out_valid && (out_idx_q == IDX_W'(NUM_WORDS - 1));
    assign block_done = block_done_q;
    assign occupancy  = occ_q;

    // Output framing: word index within block and the post-block pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_idx_q    <= '0;
            block_done_q <= 1'b0;
        end else begin
            block_done_q <= out_hs && out_last;
            if (out_hs) begin
                out_idx_q <= (out_idx_q == IDX_W'(NUM_WORDS - 1)) ? '0 : out_idx_q + 1'b1;
            end
        end
    end

    // Word count in flight: +1 per accepted input, -1 per delivered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            case ({in_hs, out_hs})
                2'b10:   occ_q <= occ_q + 4'd1;
                2'b01:   occ_q <= occ_q - 4'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule
